// File: rtl/jacobi_grid_streamer_pkg.sv
// Shared definitions for the Jacobi solver blocks: default sizes, grid-size
// constants, the streamer state encoding and the fixed-point magnitude helper.
package jacobi_pkg;

    localparam int M_DEFAULT     = 4;
    localparam int WIDTH_DEFAULT = 32;
    localparam int CW_DEFAULT    = 8;
    localparam int GRID_N        = M_DEFAULT + 2;
    localparam int GRID_WORDS    = GRID_N * GRID_N;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    // Two's-complement magnitude; the most-negative value maps to +2^(W-1),
    // which is still representable as an unsigned W-bit number.
    function automatic logic [WIDTH_DEFAULT-1:0] abs_fixed(input logic [WIDTH_DEFAULT-1:0] x);
        logic [WIDTH_DEFAULT-1:0] mag;
        if (x[WIDTH_DEFAULT-1]) begin
            mag = ~x + WIDTH_DEFAULT'(1);
        end else begin
            mag = x;
        end
        return mag;
    endfunction

endpackage

// File: rtl/jacobi_grid_streamer_if.sv
// Valid/ready word stream carrying one grid element plus its row/col tags
// and end-of-row / end-of-frame markers.
interface jacobi_grid_streamer_if
    import jacobi_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CW    = CW_DEFAULT
);
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [CW-1:0]    m_row;
    logic [CW-1:0]    m_col;
    logic             m_eol;
    logic             m_eof;

    modport master (output m_valid, m_data, m_row, m_col, m_eol, m_eof, input m_ready);
    modport slave  (input m_valid, m_data, m_row, m_col, m_eol, m_eof, output m_ready);
endinterface

// File: rtl/jacobi_grid_streamer_l1_accum.sv
// L1 accumulator: adds |data| to a running sum when enabled; clear wins over
// enable. sum_next exposes the post-add value so a caller can capture the
// final total in the same cycle as the last addition.
module jacobi_grid_streamer_l1_accum
    import jacobi_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int SUM_W = WIDTH_DEFAULT + 2 * CW_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] data,
    output logic [SUM_W-1:0] sum,
    output logic [SUM_W-1:0] sum_next
);
    logic [WIDTH-1:0] mag;

    if (WIDTH == WIDTH_DEFAULT) begin : g_pkg_abs
        assign mag = abs_fixed(data);
    end else begin : g_gen_abs
        assign mag = data[WIDTH-1] ? (~data + WIDTH'(1)) : data;
    end

    // Zero-extend the magnitude and form the candidate sum.
    always_comb begin
        sum_next = sum + SUM_W'(mag);
    end

    // Running sum register: clear on a new frame, add on each transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum_next;
        end else begin
            sum <= sum;
        end
    end
endmodule

// File: rtl/jacobi_grid_streamer.sv
// Captures a solved grid on load and streams it row-major over a valid/ready
// interface, then pulses the L1 norm of everything that was sent.
module jacobi_grid_streamer
    import jacobi_pkg::*;
#(
    parameter int M     = M_DEFAULT,
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CW    = CW_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load,
    input  logic [(M+2)*(M+2)*WIDTH-1:0]   grid_flat,
    output logic                           busy,
    jacobi_grid_streamer_if.master         strm,
    output logic                           norm_valid,
    output logic [WIDTH+2*CW-1:0]          norm_l1
);
    localparam int N     = M + 2;
    localparam int WORDS = N * N;
    localparam int IW    = $clog2(WORDS);
    localparam int SUM_W = WIDTH + 2 * CW;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t            state, state_next;
    logic              accept, xfer, last_xfer;
    logic [CW-1:0]     row_next, col_next;
    logic [IW-1:0]     idx_next;
    logic [WIDTH-1:0]  frame_buf [WORDS];
    logic [SUM_W-1:0]  acc_sum, acc_next;

    // Next-state and handshake decode; a load is only honoured in IDLE.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        xfer       = 1'b0;
        last_xfer  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    accept     = 1'b1;
                    state_next = ST_STREAM;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_STREAM: begin
                xfer = strm.m_valid & strm.m_ready;
                if (xfer && strm.m_eof) begin
                    last_xfer  = 1'b1;
                    state_next = ST_REPORT;
                end else begin
                    state_next = ST_STREAM;
                end
            end
            ST_REPORT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Row/col successor; the buffer address is row*N+col (constant multiply).
    always_comb begin
        if (strm.m_col == LAST) begin
            col_next = '0;
            row_next = strm.m_row + CW'(1);
        end else begin
            col_next = strm.m_col + CW'(1);
            row_next = strm.m_row;
        end
        idx_next = IW'(row_next * N) + IW'(col_next);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame buffer: deliberately not reset, only overwritten by an accepted load.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < WORDS; k++) begin
                frame_buf[k] <= grid_flat[k*WIDTH +: WIDTH];
            end
        end
    end

    // Registered stream outputs, status flags and the held norm.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy         <= 1'b0;
            strm.m_valid <= 1'b0;
            strm.m_data  <= '0;
            strm.m_row   <= '0;
            strm.m_col   <= '0;
            strm.m_eol   <= 1'b0;
            strm.m_eof   <= 1'b0;
            norm_valid   <= 1'b0;
            norm_l1      <= '0;
        end else begin
            busy         <= (state_next != ST_IDLE);
            strm.m_valid <= (state_next == ST_STREAM);
            norm_valid   <= last_xfer;
            if (accept) begin
                // Word 0 comes straight from the bus: the buffer fills this same edge.
                strm.m_data <= grid_flat[0 +: WIDTH];
                strm.m_row  <= '0;
                strm.m_col  <= '0;
                strm.m_eol  <= 1'b0;
                strm.m_eof  <= 1'b0;
            end else if (xfer && !last_xfer) begin
                strm.m_data <= frame_buf[idx_next];
                strm.m_row  <= row_next;
                strm.m_col  <= col_next;
                strm.m_eol  <= (col_next == LAST);
                strm.m_eof  <= (col_next == LAST) && (row_next == LAST);
            end else begin
                strm.m_data <= strm.m_data;
                strm.m_row  <= strm.m_row;
                strm.m_col  <= strm.m_col;
                strm.m_eol  <= strm.m_eol;
                strm.m_eof  <= strm.m_eof;
            end
            if (last_xfer) begin
                norm_l1 <= acc_next;
            end else begin
                norm_l1 <= norm_l1;
            end
        end
    end

    jacobi_grid_streamer_l1_accum #(
        .WIDTH (WIDTH),
        .SUM_W (SUM_W)
    ) u_l1_accum (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept),
        .en       (xfer),
        .data     (strm.m_data),
        .sum      (acc_sum),
        .sum_next (acc_next)
    );
endmodule
